// File: rtl/logical_pkg.sv
// Shared definitions for the frame-wide logical reduction pipeline:
// mode encodings, the frame state type and the popcount width helper.
package logical_pkg;

    localparam logic [1:0] LAND = 2'd0;
    localparam logic [1:0] LOR  = 2'd1;
    localparam logic [1:0] LXOR = 2'd2;
    localparam logic [1:0] LNOR = 2'd3;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_ACC  = 1'b1
    } state_t;

    // Bits needed to hold a count of 0..n true operands.
    function automatic int pcnt_w(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/logical_beat_reduce.sv
// Combinational per-beat reduction: truth of each operand (operand != 0),
// then all/any/parity/popcount across the beat.
module logical_beat_reduce
    import logical_pkg::*;
#(
    parameter int WIDTH   = 4,
    parameter int NUM_OPS = 4,
    parameter int PW      = pcnt_w(NUM_OPS)
) (
    input  logic [NUM_OPS*WIDTH-1:0] data_i,
    output logic                     all_o,
    output logic                     any_o,
    output logic                     par_o,
    output logic [PW-1:0]            pcnt_o
);

    logic [NUM_OPS-1:0] truth;

    always_comb begin
        truth = '0;
        for (int k = 0; k < NUM_OPS; k++) begin
            truth[k] = |data_i[k*WIDTH +: WIDTH];
        end
    end

    always_comb begin
        pcnt_o = '0;
        for (int k = 0; k < NUM_OPS; k++) begin
            pcnt_o = pcnt_o + PW'(truth[k]);
        end
    end

    assign all_o = &truth;
    assign any_o = |truth;
    assign par_o = ^truth;

endmodule

// File: rtl/logical_reduce_pipe.sv
// Frame-wide logical reduction: accumulates per-beat all/any/parity/count
// across a frame and returns one registered result per frame over valid/ready.
module logical_reduce_pipe
    import logical_pkg::*;
#(
    parameter int WIDTH   = 4,
    parameter int NUM_OPS = 4,
    parameter int CNT_W   = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [NUM_OPS*WIDTH-1:0] in_data,
    input  logic                     in_last,
    input  logic [1:0]               mode,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic                     out_result,
    output logic [CNT_W-1:0]         out_cnt
);

    localparam int PW    = pcnt_w(NUM_OPS);
    localparam int SUM_W = ((CNT_W > PW) ? CNT_W : PW) + 1;
    localparam logic [SUM_W-1:0] CNT_MAX = {{(SUM_W-CNT_W){1'b0}}, {CNT_W{1'b1}}};

    function automatic logic [CNT_W-1:0] sat_cnt(input logic [SUM_W-1:0] v);
        if (v > CNT_MAX) return {CNT_W{1'b1}};
        return v[CNT_W-1:0];
    endfunction

    function automatic logic apply_mode(input logic [1:0] m, input logic a,
                                        input logic o, input logic x);
        case (m)
            LAND:    return a;
            LOR:     return o;
            LXOR:    return x;
            default: return ~o;
        endcase
    endfunction

    logic          b_all, b_any, b_par;
    logic [PW-1:0] b_pcnt;

    logical_beat_reduce #(
        .WIDTH   (WIDTH),
        .NUM_OPS (NUM_OPS),
        .PW      (PW)
    ) u_beat (
        .data_i (in_data),
        .all_o  (b_all),
        .any_o  (b_any),
        .par_o  (b_par),
        .pcnt_o (b_pcnt)
    );

    state_t           state_q, state_d;
    logic [1:0]       mode_q, mode_d;
    logic             and_q, and_d, or_q, or_d, xor_q, xor_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             out_valid_q, out_valid_d;
    logic             out_result_q, out_result_d;
    logic [CNT_W-1:0] out_cnt_q, out_cnt_d;

    logic accept, first;

    assign in_ready = ~out_valid_q | out_ready;
    assign accept   = in_valid & in_ready;
    assign first    = (state_q == S_IDLE);

    always_comb begin
        state_d      = state_q;
        mode_d       = mode_q;
        and_d        = and_q;
        or_d         = or_q;
        xor_d        = xor_q;
        cnt_d        = cnt_q;
        out_valid_d  = out_valid_q;
        out_result_d = out_result_q;
        out_cnt_d    = out_cnt_q;

        // The first beat of a frame seeds the accumulators instead of merging.
        if (accept) begin
            mode_d  = first ? mode : mode_q;
            and_d   = first ? b_all : (and_q & b_all);
            or_d    = first ? b_any : (or_q | b_any);
            xor_d   = first ? b_par : (xor_q ^ b_par);
            cnt_d   = sat_cnt(first ? SUM_W'(b_pcnt)
                                    : SUM_W'(cnt_q) + SUM_W'(b_pcnt));
            state_d = in_last ? S_IDLE : S_ACC;
        end

        if (out_valid_q & out_ready) out_valid_d = 1'b0;

        if (accept & in_last) begin
            out_valid_d  = 1'b1;
            out_result_d = apply_mode(mode_d, and_d, or_d, xor_d);
            out_cnt_d    = cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            mode_q       <= LAND;
            and_q        <= 1'b0;
            or_q         <= 1'b0;
            xor_q        <= 1'b0;
            cnt_q        <= '0;
            out_valid_q  <= 1'b0;
            out_result_q <= 1'b0;
            out_cnt_q    <= '0;
        end else begin
            state_q      <= state_d;
            mode_q       <= mode_d;
            and_q        <= and_d;
            or_q         <= or_d;
            xor_q        <= xor_d;
            cnt_q        <= cnt_d;
            out_valid_q  <= out_valid_d;
            out_result_q <= out_result_d;
            out_cnt_q    <= out_cnt_d;
        end
    end

    assign out_valid  = out_valid_q;
    assign out_result = out_result_q;
    assign out_cnt    = out_cnt_q;

endmodule

// File: tb/tb_logical_reduce_pipe.sv
// Bench for logical_reduce_pipe: directed frames plus random traffic, checked
// against a frame-level truth-count model (default CNT_W and a CNT_W=3 copy).
module tb_logical_reduce_pipe;

    localparam int WIDTH   = 4;
    localparam int NUM_OPS = 4;
    localparam int DW      = WIDTH * NUM_OPS;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_valid = 1'b0;
    logic          in_last = 1'b0;
    logic          out_ready = 1'b1;
    logic [1:0]    mode = 2'd0;
    logic [DW-1:0] in_data = '0;

    wire       in_ready, out_valid, out_result;
    wire [7:0] out_cnt;
    wire       in_ready3, out_valid3, out_result3;
    wire [2:0] out_cnt3;

    always #5 clk = ~clk;

    logical_reduce_pipe #(.WIDTH(WIDTH), .NUM_OPS(NUM_OPS), .CNT_W(8)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_last(in_last), .mode(mode),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_result(out_result), .out_cnt(out_cnt)
    );

    logical_reduce_pipe #(.WIDTH(WIDTH), .NUM_OPS(NUM_OPS), .CNT_W(3)) dut3 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready3),
        .in_data(in_data), .in_last(in_last), .mode(mode),
        .out_valid(out_valid3), .out_ready(out_ready),
        .out_result(out_result3), .out_cnt(out_cnt3)
    );

    int n_chk = 0;
    int n_bad = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference: one entry per completed, not yet consumed frame.
    typedef struct {
        bit res;
        int trues;
    } exp_t;
    exp_t expq[$];

    bit in_frame = 0;
    int f_mode, f_true, f_ops;
    bit rand_ready = 0;

    function automatic exp_t frame_result(input int m, input int trues, input int ops);
        exp_t e;
        bit all_t, any_t, odd_t;
        all_t = (trues == ops);
        any_t = (trues > 0);
        odd_t = (trues % 2) == 1;
        case (m)
            0:       e.res = all_t;
            1:       e.res = any_t;
            2:       e.res = odd_t;
            default: e.res = !any_t;
        endcase
        e.trues = trues;
        return e;
    endfunction

    function automatic int clampi(input int v, input int mx);
        return (v > mx) ? mx : v;
    endfunction

    always @(negedge clk) begin
        bit exp_rdy;
        if (rst) begin
            expq.delete();
            in_frame = 0;
        end else begin
            exp_rdy = (expq.size() == 0) || out_ready;
            check_eq("out_valid", out_valid, expq.size() > 0);
            check_eq("out_valid3", out_valid3, expq.size() > 0);
            check_eq("in_ready", in_ready, exp_rdy);
            check_eq("in_ready3", in_ready3, exp_rdy);
            if (expq.size() > 0) begin
                check_eq("out_result", out_result, expq[0].res);
                check_eq("out_cnt", out_cnt, clampi(expq[0].trues, 255));
                check_eq("out_result3", out_result3, expq[0].res);
                check_eq("out_cnt3", out_cnt3, clampi(expq[0].trues, 7));
                if (out_ready) void'(expq.pop_front());
            end
            if (in_valid && exp_rdy) begin
                if (!in_frame) begin
                    f_mode = mode;
                    f_true = 0;
                    f_ops  = 0;
                end
                for (int k = 0; k < NUM_OPS; k++)
                    if (in_data[k*WIDTH +: WIDTH] != 0) f_true++;
                f_ops += NUM_OPS;
                if (in_last) begin
                    expq.push_back(frame_result(f_mode, f_true, f_ops));
                    in_frame = 0;
                end else begin
                    in_frame = 1;
                end
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_beat(input logic [DW-1:0] d, input bit last, input logic [1:0] m);
        bit acc;
        int guard;
        guard = 0;
        in_valid = 1'b1;
        in_data  = d;
        in_last  = last;
        mode     = m;
        do begin
            if (rand_ready) out_ready = 1'($urandom_range(0, 1));
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
            guard++;
        end while (!acc && guard < 500);
        if (!acc) check_eq("accept_timeout", 0, 1);
        in_valid = 1'b0;
    endtask

    function automatic logic [DW-1:0] rand_beat();
        logic [DW-1:0] d;
        d = '0;
        for (int k = 0; k < NUM_OPS; k++)
            if ($urandom_range(0, 1) == 1) d[k*WIDTH +: WIDTH] = WIDTH'($urandom_range(1, 15));
        return d;
    endfunction

    initial begin
        #500000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int len;
        idle(3);
        rst = 1'b0;
        @(negedge clk);
        check_eq("rst_out_valid", out_valid, 0);
        check_eq("rst_out_result", out_result, 0);
        check_eq("rst_out_cnt", out_cnt, 0);
        check_eq("rst_in_ready", in_ready, 1);
        @(posedge clk);
        #1;

        // Single-beat frames, mode cycled 0..3 (operands 1111,1010,1001,1101).
        for (int m = 0; m < 4; m++) send_beat(16'hD9AF, 1'b1, 2'(m));
        idle(2);

        // Two trues (0000,1010,0000,0001) under LAND and LXOR.
        send_beat(16'h10A0, 1'b1, LAND_M());
        send_beat(16'h10A0, 1'b1, 2'd2);
        idle(2);

        // Three-beat frame; mode changes on later beats are ignored.
        send_beat(16'h0000, 1'b0, 2'd1);
        send_beat(16'h0000, 1'b0, 2'd0);
        send_beat(16'h0300, 1'b1, 2'd0);
        idle(2);

        // Twelve trues: saturates the CNT_W=3 copy.
        for (int b = 0; b < 3; b++) send_beat(16'h1111, b == 2, 2'd0);
        idle(2);

        // 280 trues: saturates the default 8-bit counter.
        for (int b = 0; b < 70; b++) send_beat(16'hFFFF, b == 69, 2'd2);
        idle(2);

        // Back-pressure, then release while a completing beat is offered.
        out_ready = 1'b1;
        send_beat(16'h0001, 1'b1, 2'd1);
        out_ready = 1'b0;
        fork
            send_beat(16'h00F0, 1'b1, 2'd0);
            begin
                idle(5);
                out_ready = 1'b1;
            end
        join
        idle(3);

        // Reset on beat 2 of an open frame.
        send_beat(16'h1111, 1'b0, 2'd0);
        in_valid = 1'b1;
        in_data  = 16'h2222;
        in_last  = 1'b0;
        rst      = 1'b1;
        idle(1);
        rst      = 1'b0;
        in_valid = 1'b0;
        send_beat(16'h0000, 1'b1, 2'd3);
        idle(2);

        // Reset while a result is held.
        out_ready = 1'b0;
        send_beat(16'h0F00, 1'b1, 2'd1);
        idle(2);
        rst = 1'b1;
        idle(1);
        rst = 1'b0;
        out_ready = 1'b1;
        idle(2);

        // Random frames with random consumer stalls.
        rand_ready = 1;
        for (int f = 0; f < 150; f++) begin
            len = $urandom_range(1, 4);
            for (int b = 0; b < len; b++)
                send_beat(rand_beat(), b == len - 1, 2'($urandom_range(0, 3)));
            if ($urandom_range(0, 3) == 0) idle(1);
        end
        rand_ready = 0;
        out_ready  = 1'b1;
        idle(4);
        check_eq("drain_empty", expq.size(), 0);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

    function automatic logic [1:0] LAND_M();
        return 2'd0;
    endfunction

endmodule
